// File: rtl/tdm_demux.sv
// Receive side of a 4:1 TDM link: slot counter, frame-lock FSM with flywheel,
// and atomic per-frame channel outputs. Optional parity check: TDM_DEMUX_PARITY_EN.
//
// state | meaning
// HUNT  | waiting for FSYNC; samples discarded, SLOT held at 0
// LOCK  | framed; each valid sample goes to shadow[SLOT], slot 3 completes a frame
module tdm_demux #(
    parameter int W          = 8,
    parameter int MISS_LIMIT = 2
) (
    input  logic         CLK,
    input  logic         RST_N,
    input  logic [W-1:0] DIN,
    input  logic         DIN_VALID,
    input  logic         FSYNC,
`ifdef TDM_DEMUX_PARITY_EN
    input  logic         DIN_PAR,
    output logic         PAR_ERR,
`endif
    output logic [W-1:0] Y0,
    output logic [W-1:0] Y1,
    output logic [W-1:0] Y2,
    output logic [W-1:0] Y3,
    output logic         Y_VALID,
    output logic         LOCKED,
    output logic [1:0]   SLOT,
    output logic         FRAME_ERR
);

    typedef enum logic {HUNT = 1'b0, LOCK = 1'b1} state_t;

    localparam logic [2:0] MISS_MAX = 3'(MISS_LIMIT);

    state_t       state_q, state_d;
    logic [1:0]   slot_q, slot_d;
    logic [2:0]   miss_q, miss_d;
    logic [2:0]   miss_inc;
    logic [W-1:0] sh0_q, sh0_d, sh1_q, sh1_d, sh2_q, sh2_d;
    logic [W-1:0] y0_d, y1_d, y2_d, y3_d;
    logic         y_valid_d, frame_err_d;
    logic         complete;
    logic         frame_bad;

    assign miss_inc = miss_q + 3'd1;
    assign complete = DIN_VALID && (state_q == LOCK) && (slot_q == 2'd3) && !FSYNC;

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            state_q   <= HUNT;
            slot_q    <= 2'd0;
            miss_q    <= 3'd0;
            sh0_q     <= '0;
            sh1_q     <= '0;
            sh2_q     <= '0;
            Y0        <= '0;
            Y1        <= '0;
            Y2        <= '0;
            Y3        <= '0;
            Y_VALID   <= 1'b0;
            FRAME_ERR <= 1'b0;
        end else begin
            state_q   <= state_d;
            slot_q    <= slot_d;
            miss_q    <= miss_d;
            sh0_q     <= sh0_d;
            sh1_q     <= sh1_d;
            sh2_q     <= sh2_d;
            Y0        <= y0_d;
            Y1        <= y1_d;
            Y2        <= y2_d;
            Y3        <= y3_d;
            Y_VALID   <= y_valid_d;
            FRAME_ERR <= frame_err_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        slot_d      = slot_q;
        miss_d      = miss_q;
        sh0_d       = sh0_q;
        sh1_d       = sh1_q;
        sh2_d       = sh2_q;
        y0_d        = Y0;
        y1_d        = Y1;
        y2_d        = Y2;
        y3_d        = Y3;
        y_valid_d   = 1'b0;
        frame_err_d = 1'b0;
        if (DIN_VALID) begin
            if (state_q == HUNT) begin
                if (FSYNC) begin
                    sh0_d   = DIN;
                    slot_d  = 2'd1;
                    miss_d  = 3'd0;
                    state_d = LOCK;
                end
            end else if (slot_q == 2'd0) begin
                if (!FSYNC && miss_inc == MISS_MAX) begin
                    // Too many missing syncs: drop this sample and re-hunt.
                    state_d = HUNT;
                    slot_d  = 2'd0;
                    miss_d  = 3'd0;
                end else begin
                    sh0_d  = DIN;
                    slot_d = 2'd1;
                    miss_d = FSYNC ? 3'd0 : miss_inc;
                end
            end else if (FSYNC) begin
                frame_err_d = 1'b1;
                sh0_d       = DIN;
                slot_d      = 2'd1;
                miss_d      = 3'd0;
            end else begin
                slot_d = slot_q + 2'd1;
                if (slot_q == 2'd1) sh1_d = DIN;
                if (slot_q == 2'd2) sh2_d = DIN;
                if (complete && !frame_bad) begin
                    y0_d      = sh0_q;
                    y1_d      = sh1_q;
                    y2_d      = sh2_q;
                    y3_d      = DIN;
                    y_valid_d = 1'b1;
                end
            end
        end
    end

    assign LOCKED = (state_q == LOCK);
    assign SLOT   = slot_q;

`ifdef TDM_DEMUX_PARITY_EN
    logic sample_bad;
    logic par_flag_q, par_flag_d;

    assign sample_bad = (^DIN) ^ DIN_PAR;
    assign frame_bad  = par_flag_q | sample_bad;

    // Slot 0 starts a new frame's flag; slots 1..2 accumulate; anything else clears.
    always_comb begin
        par_flag_d = par_flag_q;
        if (DIN_VALID) begin
            if (slot_d == 2'd1)
                par_flag_d = sample_bad;
            else if (state_d == LOCK && slot_d != 2'd0)
                par_flag_d = par_flag_q | sample_bad;
            else
                par_flag_d = 1'b0;
        end
    end

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            par_flag_q <= 1'b0;
            PAR_ERR    <= 1'b0;
        end else begin
            par_flag_q <= par_flag_d;
            PAR_ERR    <= complete & frame_bad;
        end
    end
`else
    assign frame_bad = 1'b0;
`endif

endmodule

// File: tb/tb_tdm_demux.sv
// Directed bench for tdm_demux: lock, gaps, streaming, resync, flywheel, reset, parity.
module tb_tdm_demux;

    logic       CLK = 1'b0;
    logic       RST_N;
    logic [7:0] DIN;
    logic       DIN_VALID;
    logic       FSYNC;
    logic [7:0] Y0, Y1, Y2, Y3;
    logic       Y_VALID, LOCKED, FRAME_ERR;
    logic [1:0] SLOT;
`ifdef TDM_DEMUX_PARITY_EN
    logic       DIN_PAR;
    logic       PAR_ERR;
`endif

    int checks   = 0;
    int failures = 0;

    tdm_demux #(.W(8), .MISS_LIMIT(2)) dut (
        .CLK       (CLK),
        .RST_N     (RST_N),
        .DIN       (DIN),
        .DIN_VALID (DIN_VALID),
        .FSYNC     (FSYNC),
`ifdef TDM_DEMUX_PARITY_EN
        .DIN_PAR   (DIN_PAR),
        .PAR_ERR   (PAR_ERR),
`endif
        .Y0        (Y0),
        .Y1        (Y1),
        .Y2        (Y2),
        .Y3        (Y3),
        .Y_VALID   (Y_VALID),
        .LOCKED    (LOCKED),
        .SLOT      (SLOT),
        .FRAME_ERR (FRAME_ERR)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_y(input string tag, input logic [7:0] a, input logic [7:0] b,
                           input logic [7:0] c, input logic [7:0] d);
        check({tag, ".y0"}, 32'(Y0), 32'(a));
        check({tag, ".y1"}, 32'(Y1), 32'(b));
        check({tag, ".y2"}, 32'(Y2), 32'(c));
        check({tag, ".y3"}, 32'(Y3), 32'(d));
    endtask

    // One valid sample; returns 1 time unit after the accepting edge.
    task automatic send(input logic [7:0] d, input logic fs, input logic bad_par = 1'b0);
        @(negedge CLK);
        DIN       = d;
        FSYNC     = fs;
        DIN_VALID = 1'b1;
`ifdef TDM_DEMUX_PARITY_EN
        DIN_PAR   = (^d) ^ bad_par;
`else
        if (bad_par) DIN = d;
`endif
        @(posedge CLK);
        #1;
        DIN_VALID = 1'b0;
        FSYNC     = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge CLK);
            #1;
        end
    endtask

    initial begin
        RST_N     = 1'b0;
        DIN       = 8'h00;
        DIN_VALID = 1'b0;
        FSYNC     = 1'b0;
`ifdef TDM_DEMUX_PARITY_EN
        DIN_PAR   = 1'b0;
`endif
        idle(2);
        check_y("rst", 8'h00, 8'h00, 8'h00, 8'h00);
        check("rst.yv", 32'(Y_VALID), 32'd0);
        check("rst.locked", 32'(LOCKED), 32'd0);
        check("rst.slot", 32'(SLOT), 32'd0);
        check("rst.ferr", 32'(FRAME_ERR), 32'd0);
        @(negedge CLK);
        RST_N = 1'b1;

        // Lock and first frame
        send(8'h11, 1'b1);
        check("lock.locked", 32'(LOCKED), 32'd1);
        check("lock.slot1", 32'(SLOT), 32'd1);
        send(8'h22, 1'b0);
        send(8'h33, 1'b0);
        check("lock.slot3", 32'(SLOT), 32'd3);
        check("lock.yv_early", 32'(Y_VALID), 32'd0);
        send(8'h44, 1'b0);
        check_y("frame1", 8'h11, 8'h22, 8'h33, 8'h44);
        check("frame1.yv", 32'(Y_VALID), 32'd1);
        check("frame1.slot", 32'(SLOT), 32'd0);
        idle(1);
        check("frame1.yv_pulse", 32'(Y_VALID), 32'd0);
        check_y("frame1.hold", 8'h11, 8'h22, 8'h33, 8'h44);

        // Gaps of 1..3 idle cycles between samples
        send(8'h55, 1'b1);
        idle(1);
        check("gap.slot1", 32'(SLOT), 32'd1);
        send(8'h66, 1'b0);
        idle(2);
        check("gap.slot2", 32'(SLOT), 32'd2);
        check_y("gap.hold", 8'h11, 8'h22, 8'h33, 8'h44);
        send(8'h77, 1'b0);
        idle(3);
        check("gap.slot3", 32'(SLOT), 32'd3);
        send(8'h88, 1'b0);
        check_y("gap.frame", 8'h55, 8'h66, 8'h77, 8'h88);
        check("gap.yv", 32'(Y_VALID), 32'd1);

        // Three back-to-back frames: Y_VALID every 4th cycle
        for (int f = 0; f < 3; f++) begin
            for (int s = 0; s < 4; s++) begin
                send(8'((f + 1) * 16 + s), s == 0);
                check($sformatf("b2b.f%0d.s%0d.yv", f, s), 32'(Y_VALID), (s == 3) ? 32'd1 : 32'd0);
            end
            check_y($sformatf("b2b.f%0d", f), 8'((f + 1) * 16), 8'((f + 1) * 16 + 1),
                    8'((f + 1) * 16 + 2), 8'((f + 1) * 16 + 3));
        end

        // Resync: FSYNC arrives at SLOT=2
        send(8'hB0, 1'b1);
        send(8'hB1, 1'b0);
        check("resync.slot2", 32'(SLOT), 32'd2);
        send(8'hA0, 1'b1);
        check("resync.ferr", 32'(FRAME_ERR), 32'd1);
        check("resync.yv", 32'(Y_VALID), 32'd0);
        check("resync.slot", 32'(SLOT), 32'd1);
        check_y("resync.hold", 8'h30, 8'h31, 8'h32, 8'h33);
        send(8'hA1, 1'b0);
        check("resync.ferr_pulse", 32'(FRAME_ERR), 32'd0);
        send(8'hA2, 1'b0);
        send(8'hA3, 1'b0);
        check_y("resync.frame", 8'hA0, 8'hA1, 8'hA2, 8'hA3);
        check("resync.frame_yv", 32'(Y_VALID), 32'd1);

        // Flywheel: one missing FSYNC is tolerated
        send(8'hC0, 1'b0);
        check("fly.locked", 32'(LOCKED), 32'd1);
        send(8'hC1, 1'b0);
        send(8'hC2, 1'b0);
        send(8'hC3, 1'b0);
        check_y("fly.frame", 8'hC0, 8'hC1, 8'hC2, 8'hC3);
        check("fly.yv", 32'(Y_VALID), 32'd1);

        // Second consecutive miss drops lock
        send(8'hD0, 1'b0);
        check("loss.locked", 32'(LOCKED), 32'd0);
        check("loss.slot", 32'(SLOT), 32'd0);
        send(8'hD1, 1'b0);
        send(8'hD2, 1'b0);
        send(8'hD3, 1'b0);
        check("loss.yv", 32'(Y_VALID), 32'd0);
        check("loss.still_hunt", 32'(LOCKED), 32'd0);
        check("loss.slot_hunt", 32'(SLOT), 32'd0);
        check_y("loss.hold", 8'hC0, 8'hC1, 8'hC2, 8'hC3);

        // Relock, then reset mid-frame
        send(8'hE0, 1'b1);
        check("relock.locked", 32'(LOCKED), 32'd1);
        send(8'hE1, 1'b0);
        @(negedge CLK);
        RST_N = 1'b0;
        @(posedge CLK);
        #1;
        check_y("midrst", 8'h00, 8'h00, 8'h00, 8'h00);
        check("midrst.locked", 32'(LOCKED), 32'd0);
        check("midrst.slot", 32'(SLOT), 32'd0);
        check("midrst.yv", 32'(Y_VALID), 32'd0);
        check("midrst.ferr", 32'(FRAME_ERR), 32'd0);
        @(negedge CLK);
        RST_N = 1'b1;
        FSYNC = 1'b1;
        DIN   = 8'hF0;
        @(posedge CLK);
        #1;
        FSYNC = 1'b0;
        check("nvalid_fsync.locked", 32'(LOCKED), 32'd0);
        check("nvalid_fsync.slot", 32'(SLOT), 32'd0);
        send(8'hF1, 1'b0);
        check("hunt_discard.locked", 32'(LOCKED), 32'd0);

`ifdef TDM_DEMUX_PARITY_EN
        // Clean frame, then a frame with bad parity on slot 1, then clean again
        send(8'h01, 1'b1);
        send(8'h02, 1'b0);
        send(8'h03, 1'b0);
        send(8'h04, 1'b0);
        check_y("par.clean", 8'h01, 8'h02, 8'h03, 8'h04);
        check("par.clean_perr", 32'(PAR_ERR), 32'd0);
        send(8'h05, 1'b1);
        send(8'h06, 1'b0, 1'b1);
        send(8'h07, 1'b0);
        send(8'h08, 1'b0);
        check("par.bad_perr", 32'(PAR_ERR), 32'd1);
        check("par.bad_yv", 32'(Y_VALID), 32'd0);
        check_y("par.bad_hold", 8'h01, 8'h02, 8'h03, 8'h04);
        send(8'h09, 1'b1);
        check("par.perr_pulse", 32'(PAR_ERR), 32'd0);
        send(8'h0A, 1'b0);
        send(8'h0B, 1'b0);
        send(8'h0C, 1'b0);
        check_y("par.next", 8'h09, 8'h0A, 8'h0B, 8'h0C);
        check("par.next_yv", 32'(Y_VALID), 32'd1);
        check("par.next_perr", 32'(PAR_ERR), 32'd0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
